// File: rtl/rgb_matrix_pkg.sv
// Shared definitions for the RGB matrix shifter.
//   mode_e    : step operation selected by the 2-bit mode input
//   colour_e  : colour index driven on led_out
//   seed_pattern(mode, n) : one-hot start pattern for an n-bit matrix
package rgb_matrix_pkg;

  // Widest pattern seed_pattern can produce; callers truncate to their own N.
  localparam int unsigned MAX_N = 256;

  typedef enum logic [1:0] {
    MODE_SHL = 2'b00,
    MODE_SHR = 2'b01,
    MODE_ROL = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    COL_RED   = 2'd0,
    COL_GREEN = 2'd1,
    COL_BLUE  = 2'd2,
    COL_WHITE = 2'd3
  } colour_e;

  // Left-moving modes start at bit 0, right-moving modes at bit n-1, so the
  // lit bit always has the full pattern width to travel across.
  function automatic logic [MAX_N-1:0] seed_pattern(input logic [1:0] mode,
                                                    input int unsigned n);
    logic [MAX_N-1:0] one;
    one = MAX_N'(1);
    if (mode == MODE_SHR || mode == MODE_ROR) begin
      return one << (n - 1);
    end
    return one;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, debounced
// level and a single-cycle press strobe on the debounced 0->1 edge.
//   clk_i    : system clock
//   rst_ni   : synchronous reset, active-low
//   btn_i    : raw asynchronous button, active-high
//   level_o  : debounced button level
//   press_o  : one-cycle strobe on an accepted press (release gives nothing)
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [1:0]      vld_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            armed_q, armed_d;
  logic            press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    // A button held through reset must not count as a press: only arm once
    // the synchroniser holds a real sample and that sample is low.
    armed_d = armed_q | (vld_q[1] & ~sync_q[1]);
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        cnt_d   = '0;
        level_d = sync_q[1];
        press_d = sync_q[1] & armed_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Any bounce back to the accepted level restarts the count.
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      vld_q   <= {vld_q[0], 1'b1};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/rgb_matrix_shifter.sv
// One-hot pattern shifter for a ROWS x COLS RGB LED matrix. Steps come from a
// debounced button press or, with auto_en set, from an internal step timer.
// Four shift/rotate modes; the colour advances each time the pattern wraps.
//   clk, rst_n : clock, synchronous active-low reset
//   button     : raw push-button, active-high
//   mode       : 00 shl, 01 shr, 10 rol, 11 ror
//   auto_en    : 1 = timer stepping (press restarts), 0 = press stepping
//   R, G, B    : per-channel column data (N = ROWS*COLS bits)
//   led_out    : colour index (0 red, 1 green, 2 blue, 3 white)
//   step_pulse : one-cycle strobe with every applied step
module rgb_matrix_shifter
  import rgb_matrix_pkg::*;
#(
  parameter int unsigned ROWS            = 5,
  parameter int unsigned COLS            = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned STEP_CYCLES     = 12500000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   button,
  input  logic [1:0]             mode,
  input  logic                   auto_en,
  output logic [ROWS*COLS-1:0]   R,
  output logic [ROWS*COLS-1:0]   G,
  output logic [ROWS*COLS-1:0]   B,
  output logic [1:0]             led_out,
  output logic                   step_pulse
);

  localparam int unsigned N = ROWS * COLS;
  localparam int unsigned TimerW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(STEP_CYCLES - 1);

  logic              btn_press;
  logic              unused_btn_level;

  logic [N-1:0]      pat_q, pat_d;
  logic [1:0]        col_q, col_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              auto_en_q;
  logic [N-1:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic              pulse_q;

  logic [N-1:0]      seed_cur;
  logic [N-1:0]      shifted;
  logic              wrap;
  logic              auto_chg;
  logic              tick;
  logic              step;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .btn_i  (button),
    .level_o(unused_btn_level),
    .press_o(btn_press)
  );

  assign seed_cur = N'(seed_pattern(mode, N));

  // Candidate next pattern for the current mode and whether it wraps.
  always_comb begin
    shifted = '0;
    wrap    = 1'b0;
    unique case (mode_e'(mode))
      MODE_SHL: begin
        shifted = pat_q << 1;
        wrap    = ~|shifted;
      end
      MODE_SHR: begin
        shifted = pat_q >> 1;
        wrap    = ~|shifted;
      end
      MODE_ROL: begin
        shifted = (pat_q << 1) | (pat_q >> (N - 1));
        wrap    = pat_q[N-1];
      end
      MODE_ROR: begin
        shifted = (pat_q >> 1) | (pat_q << (N - 1));
        wrap    = pat_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    pat_d    = pat_q;
    col_d    = col_q;
    step     = 1'b0;
    auto_chg = (auto_en != auto_en_q);
    tick     = auto_en & ~auto_chg & (timer_q == TimerMax);

    if (!auto_en || auto_chg || tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    if (auto_en && btn_press) begin
      // Restart wins over a coincident tick and is not a step.
      pat_d   = seed_cur;
      col_d   = COL_RED;
      timer_d = '0;
    end else if (btn_press || tick) begin
      step = 1'b1;
      if (wrap) begin
        col_d = col_q + 2'd1;
        // Shifts lose their bit off the edge and need a fresh seed; rotates
        // already carry it round.
        pat_d = mode[1] ? shifted : seed_cur;
      end else begin
        pat_d = shifted;
      end
    end

    r_d = (col_d == COL_RED   || col_d == COL_WHITE) ? pat_d : '0;
    g_d = (col_d == COL_GREEN || col_d == COL_WHITE) ? pat_d : '0;
    b_d = (col_d == COL_BLUE  || col_d == COL_WHITE) ? pat_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q     <= seed_cur;
      col_q     <= COL_RED;
      timer_q   <= '0;
      auto_en_q <= auto_en;
      r_q       <= seed_cur;
      g_q       <= '0;
      b_q       <= '0;
      pulse_q   <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      col_q     <= col_d;
      timer_q   <= timer_d;
      auto_en_q <= auto_en;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      pulse_q   <= step;
    end
  end

  assign R          = r_q;
  assign G          = g_q;
  assign B          = b_q;
  assign led_out    = col_q;
  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_rgb_matrix_shifter.sv
module tb_rgb_matrix_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       button;
  logic [1:0] mode;
  logic       auto_en;
  logic [3:0] R, G, B;
  logic [1:0] led_out;
  logic       step_pulse;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int base;

  rgb_matrix_shifter #(
    .ROWS(2),
    .COLS(2),
    .DEBOUNCE_CYCLES(4),
    .STEP_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .mode      (mode),
    .auto_en   (auto_en),
    .R         (R),
    .G         (G),
    .B         (B),
    .led_out   (led_out),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] er, input logic [3:0] eg,
                         input logic [3:0] eb, input logic [1:0] eled);
    chk({tag, ".R"}, {28'd0, R}, {28'd0, er});
    chk({tag, ".G"}, {28'd0, G}, {28'd0, eg});
    chk({tag, ".B"}, {28'd0, B}, {28'd0, eb});
    chk({tag, ".led"}, {30'd0, led_out}, {30'd0, eled});
  endtask

  // Raw edge lands before edge 1; the step must show up at edge 7, not edge 6.
  task automatic do_press(input string tag);
    button = 1'b1;
    cycles(6);
    chk({tag, ".early"}, {31'd0, step_pulse}, 32'd0);
    cycles(1);
    chk({tag, ".pulse"}, {31'd0, step_pulse}, 32'd1);
    button = 1'b0;
    cycles(8);
  endtask

  initial begin
    rst_n   = 1'b0;
    button  = 1'b0;
    mode    = 2'b00;
    auto_en = 1'b0;
    cycles(3);
    chk_out("reset", 4'b0001, 4'b0000, 4'b0000, 2'd0);
    chk("reset.pulse", {31'd0, step_pulse}, 32'd0);
    rst_n = 1'b1;
    cycles(5);

    // 3-cycle glitch is one short of the debounce window
    base   = pulse_cnt;
    button = 1'b1;
    cycles(3);
    button = 1'b0;
    cycles(10);
    chk_out("glitch", 4'b0001, 4'b0000, 4'b0000, 2'd0);
    chk("glitch.pulses", pulse_cnt - base, 32'd0);

    // shift-left through the pattern, fourth press reloads and goes green
    base = pulse_cnt;
    do_press("shl1");
    chk_out("shl1", 4'b0010, 4'b0000, 4'b0000, 2'd0);
    do_press("shl2");
    chk_out("shl2", 4'b0100, 4'b0000, 4'b0000, 2'd0);
    do_press("shl3");
    chk_out("shl3", 4'b1000, 4'b0000, 4'b0000, 2'd0);
    do_press("shl4");
    chk_out("shl4", 4'b0000, 4'b0001, 4'b0000, 2'd1);
    chk("shl.pulses", pulse_cnt - base, 32'd4);

    // mode change alone does nothing; next shr step drops the bit, reseeds at MSB
    mode = 2'b01;
    cycles(6);
    chk_out("modechg", 4'b0000, 4'b0001, 4'b0000, 2'd1);
    chk("modechg.pulse", {31'd0, step_pulse}, 32'd0);
    do_press("shr");
    chk_out("shr", 4'b0000, 4'b0000, 4'b1000, 2'd2);

    // rotate-left colour walk
    mode  = 2'b10;
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    chk_out("rol.reset", 4'b0001, 4'b0000, 4'b0000, 2'd0);
    cycles(4);
    for (int i = 0; i < 3; i++) do_press("rol.a");
    chk_out("rol.r1000", 4'b1000, 4'b0000, 4'b0000, 2'd0);
    do_press("rol.b");
    chk_out("rol.green", 4'b0000, 4'b0001, 4'b0000, 2'd1);
    for (int i = 0; i < 4; i++) do_press("rol.c");
    chk_out("rol.blue", 4'b0000, 4'b0000, 4'b0001, 2'd2);
    for (int i = 0; i < 4; i++) do_press("rol.d");
    chk_out("rol.white", 4'b0001, 4'b0001, 4'b0001, 2'd3);
    for (int i = 0; i < 3; i++) do_press("rol.e");
    chk_out("rol.white8", 4'b1000, 4'b1000, 4'b1000, 2'd3);
    do_press("rol.f");
    chk_out("rol.red", 4'b0001, 4'b0000, 4'b0000, 2'd0);

    // auto stepping, rotate-right
    mode    = 2'b11;
    auto_en = 1'b1;
    rst_n   = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    chk_out("auto.reset", 4'b1000, 4'b0000, 4'b0000, 2'd0);
    cycles(7);
    chk("auto.t7.pulse", {31'd0, step_pulse}, 32'd0);
    chk_out("auto.t7", 4'b1000, 4'b0000, 4'b0000, 2'd0);
    cycles(1);
    chk("auto.t8.pulse", {31'd0, step_pulse}, 32'd1);
    chk_out("auto.t8", 4'b0100, 4'b0000, 4'b0000, 2'd0);
    cycles(8);
    chk_out("auto.t16", 4'b0010, 4'b0000, 4'b0000, 2'd0);
    cycles(8);
    chk_out("auto.t24", 4'b0001, 4'b0000, 4'b0000, 2'd0);
    cycles(8);
    chk("auto.t32.pulse", {31'd0, step_pulse}, 32'd1);
    chk_out("auto.t32", 4'b0000, 4'b1000, 4'b0000, 2'd1);

    // press lands on the same cycle as the tick at t40: restart, no step
    cycles(1);
    base   = pulse_cnt;
    button = 1'b1;
    cycles(7);
    chk("restart.pulse", {31'd0, step_pulse}, 32'd0);
    chk_out("restart", 4'b1000, 4'b0000, 4'b0000, 2'd0);
    button = 1'b0;
    cycles(7);
    chk("restart.t47.pulse", {31'd0, step_pulse}, 32'd0);
    chk("restart.pulses", pulse_cnt - base, 32'd0);
    cycles(1);
    chk("restart.t48.pulse", {31'd0, step_pulse}, 32'd1);
    chk_out("restart.t48", 4'b0100, 4'b0000, 4'b0000, 2'd0);

    // reset mid-debounce with button held; held level must not become a press
    auto_en = 1'b0;
    mode    = 2'b00;
    cycles(2);
    button = 1'b1;
    cycles(3);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    chk_out("held.reset", 4'b0001, 4'b0000, 4'b0000, 2'd0);
    base = pulse_cnt;
    cycles(20);
    chk("held.pulses", pulse_cnt - base, 32'd0);
    chk_out("held", 4'b0001, 4'b0000, 4'b0000, 2'd0);
    button = 1'b0;
    cycles(10);
    do_press("post_rst");
    chk_out("post_rst", 4'b0010, 4'b0000, 4'b0000, 2'd0);
    chk("post_rst.pulses", pulse_cnt - base, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
